// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package mdu_seq_pkg;

    // Operation select presented on the op port.
    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_e;

    // Control states of the iteration FSM.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, try to subtract the divisor, keep the difference if it fits.
module mdu_seq_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  bit_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    // The shifted remainder needs one extra bit before the trial subtraction.
    logic [DATA_WIDTH:0] partial;

    // Trial subtraction; a divisor of zero always subtracts, giving q=1.
    always_comb begin
        partial = {rem_in, bit_in};
        q_bit   = (partial >= {1'b0, divisor});
        // After a successful subtraction the remainder is below the divisor,
        // so the top bit is always zero and can be dropped.
        rem_out = DATA_WIDTH'(q_bit ? (partial - {1'b0, divisor}) : partial);
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle unsigned multiply/divide unit: one multiplier bit or one
// quotient bit per cycle, DATA_WIDTH iterations, then a one-cycle done pulse.
// Handshake: start is taken only in IDLE (and only without flush); busy stays
// high from the cycle after acceptance through the done cycle; done is a
// single-cycle pulse during which result is valid; result then holds.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    mdu_state_e   state, state_next;
    mdu_op_e      op_q;
    logic [W-1:0] mcand;      // multiplicand, constant during an operation
    logic [2*W-1:0] prod;     // {partial high half, remaining multiplier bits}
    logic [W-1:0] divisor;
    logic [W-1:0] dvd;        // dividend bits shift out, quotient bits shift in
    logic [W-1:0] rem;
    logic [CW-1:0] cnt;
    logic [W-1:0] result_q;

    logic         accept;
    logic         last_step;
    logic [W:0]   mul_sum;
    logic [2*W-1:0] prod_next;
    logic [W-1:0] rem_next;
    logic         q_bit;
    logic [W-1:0] dvd_next;
    logic [W-1:0] final_sel;

    mdu_seq_div_step #(.DATA_WIDTH(W)) u_div_step (
        .rem_in  (rem),
        .bit_in  (dvd[W-1]),
        .divisor (divisor),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // Next iteration values for both datapaths and the result they would give.
    always_comb begin
        accept    = (state == IDLE) && start && !flush;
        last_step = (cnt == CW'(W - 1));
        mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {mul_sum, prod[W-1:1]};
        dvd_next  = {dvd[W-2:0], q_bit};
        case (op_q)
            MDU_MUL:   final_sel = prod_next[W-1:0];
            MDU_MULHU: final_sel = prod_next[2*W-1:W];
            MDU_DIVU:  final_sel = dvd_next;
            MDU_REMU:  final_sel = rem_next;
            default:   final_sel = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and status outputs; flush always returns to IDLE silently.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: begin
                if (flush)          state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                done       = !flush;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-cycle iteration, and result load on entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MDU_MUL;
            mcand    <= '0;
            prod     <= '0;
            divisor  <= '0;
            dvd      <= '0;
            rem      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= mdu_op_e'(op);
            mcand   <= a;
            prod    <= {{W{1'b0}}, b};
            divisor <= b;
            dvd     <= a;
            rem     <= '0;
            cnt     <= '0;
        end else if (state == CALC && !flush) begin
            prod <= prod_next;
            dvd  <= dvd_next;
            rem  <= rem_next;
            cnt  <= cnt + CW'(1);
            if (last_step) result_q <= final_sel;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a cycle-level reference model and
// hand-computed expectations for each scenario.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    mdu_seq #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int t0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic definition of each operation.
    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = (2*W)'(x) * (2*W)'(y);
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (y == 0) ? {W{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Reference model: an accepted op keeps the unit busy for W+1 cycles,
    // the last of which shows the result; flush or reset abandons it.
    int           m_left = 0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_pend = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_result <= '0;
            m_pend   <= '0;
        end else if (m_left == 0) begin
            if (start && !flush) begin
                m_left <= W + 1;
                m_pend <= ref_result(op, a, b);
            end
        end else if (flush) begin
            m_left <= 0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_result <= m_pend;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", 64'(busy), 64'(m_left != 0));
            check("done", 64'(done), 64'((m_left == 1) && !flush));
            check("result", 64'(result), 64'(m_result));
        end
    end

    // Pulse start for one cycle; t0 is the edge that samples it.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk);
        #2;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #2;
        t0 = cyc;
        start = 1'b0;
    endtask

    // Move to cycle k of the current op (cycle 1 follows the accepting edge).
    task automatic wait_cycle(input int k);
        repeat ((t0 + k - 1) - cyc) @(posedge clk);
        #2;
    endtask

    // Wait (bounded) for done, then check its cycle and the result.
    task automatic wait_done(input string name, input logic [W-1:0] exp);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, 64'(found), 64'd1);
        if (found) begin
            check({name, "_cycle"}, 64'(cyc - t0 + 1), 64'd33);
            check(name, 64'(result), 64'(exp));
        end
    endtask

    int done_cnt;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        rst_n = 1'b1;

        // MUL 7*6, result held afterwards.
        issue(2'b00, 32'd7, 32'd6);
        wait_done("mul_7x6", 32'd42);
        repeat (3) @(negedge clk);
        check("mul_held", 64'(result), 64'd42);
        check("idle_busy", 64'(busy), 64'd0);

        // High and low halves of max*max, back to back.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhu_max", 32'hFFFF_FFFE);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mul_max", 32'h0000_0001);

        // Division, including divide by zero.
        issue(2'b10, 32'd100, 32'd7);
        wait_done("divu_100_7", 32'd14);
        issue(2'b11, 32'd100, 32'd7);
        wait_done("remu_100_7", 32'd2);
        issue(2'b10, 32'd5, 32'd0);
        wait_done("divu_5_0", 32'hFFFF_FFFF);
        issue(2'b11, 32'd5, 32'd0);
        wait_done("remu_5_0", 32'd5);

        // start while busy is ignored.
        issue(2'b10, 32'd100, 32'd7);
        wait_cycle(5);
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd3;
        wait_cycle(6);
        start = 1'b0;
        wait_done("divu_ignore", 32'd14);

        // Flush mid-MUL, then a fresh op.
        issue(2'b00, 32'd7, 32'd6);
        wait_cycle(10);
        flush = 1'b1;
        wait_cycle(11);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_result", 64'(result), 64'd14);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #2;
        t0 = cyc;
        start = 1'b0;
        wait_done("remu_after_flush", 32'd2);

        // Asynchronous reset mid-operation.
        issue(2'b00, 32'd3, 32'd5);
        wait_cycle(12);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("arst_no_done", 64'(done_cnt), 64'd0);
        issue(2'b00, 32'd7, 32'd6);
        wait_done("mul_after_rst", 32'd42);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle unsigned multiply/divide unit in the EX stage of the pipelined CPU.
- It takes operands from the forwarded EX operands, iterates one bit per cycle, and presents a 32-bit result.
- That result is one data input of the 4:1 write-back select mux.
- The pipeline stalls while busy is high.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle.
- op  input  2  operation: 00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder).
- a  input  DATA_WIDTH  multiplicand / dividend, captured at accepted start.
- b  input  DATA_WIDTH  multiplier / divisor, captured at accepted start.
- flush  input  1  pipeline flush; aborts any operation in progress.
- busy  output  1  high while an operation is in progress or completing.
- done  output  1  one-cycle pulse; result valid.
- result  output  DATA_WIDTH  selected result; held until the next completed operation.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - busy=0, done=0, result=0.
  - All internal registers and the counter are cleared.
  - Reset mid-operation discards the operation and produces no done.
- States:
  - IDLE -> CALC on start=1 and flush=0; a, b and op are registered and the counter is cleared.
  - CALC runs exactly DATA_WIDTH cycles, then goes to DONE.
  - DONE lasts 1 cycle, then returns to IDLE.
- busy = (state != IDLE); it is registered-state derived, with no combinational path from start.
- Latency: start is sampled at edge 0; CALC covers cycles 1..DATA_WIDTH; DONE is cycle DATA_WIDTH+1 (cycle 33 at default).
  - done=1 only in DONE.
  - result is updated at the edge entering DONE, so it is valid while done=1 and stays stable afterwards.
- Next start is accepted only in IDLE, i.e. at the earliest on the cycle after done.
- start while busy (CALC or DONE) is ignored, and operands are not re-captured.
- Multiply: shift-add over a 2*DATA_WIDTH product register, one multiplier bit per cycle.
  - MUL returns product[DATA_WIDTH-1:0].
  - MULHU returns product[2*DATA_WIDTH-1:DATA_WIDTH].
- Divide: restoring division, one quotient bit per cycle.
  - Each step uses a DATA_WIDTH+1-bit partial remainder for the trial subtraction.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: no special path and the same latency; the natural restoring result gives quotient = all ones and remainder = a.
- flush=1 in CALC or DONE:
  - Next state is IDLE; done is suppressed.
  - result keeps its previous value.
  - busy drops on the following cycle.
- flush in IDLE is a no-op; flush and start together in IDLE means flush wins and nothing is accepted.
- Counter width is $clog2(DATA_WIDTH)+1; it never wraps during an operation.
- op/a/b changing after acceptance has no effect.

Decomposition:
- Shared package:
  - op encodings MDU_MUL=2'b00, MDU_MULHU=2'b01, MDU_DIVU=2'b10, MDU_REMU=2'b11.
  - state encodings IDLE, CALC, DONE.
- Natural sub-module: mdu_div_step.
  - Combinational single restoring-division step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder and quotient bit.
  - Instantiated once and unit-testable on its own.
- The multiply step stays inline.

Test Plan:
- MUL a=7, b=6, start pulse at cycle 0 -> busy=1 cycles 1..33, done=1 only at cycle 33, result=42 and held afterwards.
- MULHU a=b=32'hFFFFFFFF -> result=32'hFFFFFFFE; back-to-back MUL of the same operands -> 32'h00000001.
- DIVU a=100, b=7 -> result=14; REMU same operands -> 2; DIVU a=5, b=0 -> 32'hFFFFFFFF; REMU a=5, b=0 -> 5; all with done at cycle 33.
- start re-asserted with different operands at cycle 5 of a DIVU 100/7 -> ignored, result still 14 at cycle 33.
- flush at cycle 10 of a MUL while result holds 14 -> busy=0 from cycle 11, no done pulse, result stays 14; new start at cycle 11 is accepted normally.
- rst_n low at cycle 12 mid-operation -> busy, done and result go 0 immediately (asynchronously); no done after release; next start completes correctly.
